irq_ctl: RTL

Interrupt controller sitting directly upstream of the PC-control decoder. It synchronises external interrupt lines, latches rising edges as pending requests, applies per-source and global masks, and drives the decoder's irq and iaBit inputs. It holds the interrupt-active state from vector entry until return-from-exception, and it records the cause index of the request being serviced.

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_sync_edge.sv | 26 ++
 rtl/irq_ctl.sv | 78 +++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state,
// default source count, cause-width sizing and the priority encoder.
package irq_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam int NUM_SRC_DEF = 4;

   function automatic int cause_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Lowest set index wins; callers zero-extend their request vector to 16 bits.
   function automatic logic [3:0] prio_idx(input logic [15:0] req);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--)
         if (req[i]) idx = 4'(i);
      return idx;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-bit two-flop synchroniser followed by a history flop;
// rise is high for one cycle after a synchronised 0->1 transition.
module irq_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic rise
);

   logic s1, s2, h;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         h  <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         h  <= s2;
      end
   end

   assign rise = s2 & ~h;

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: synchronises and edge-latches external lines,
// masks them into irq, and tracks the active/cause state for PC control.
module irq_ctl
   import irq_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int CAUSE_W = cause_width(NUM_SRC)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] int_src,
   input  logic [NUM_SRC-1:0] int_en,
   input  logic               gie,
   input  logic               take,
   input  logic               rfe,
   output logic               irq,
   output logic               ia_bit,
   output logic [CAUSE_W-1:0] cause,
   output logic [NUM_SRC-1:0] pending
);

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] clr;
   logic [15:0]        win_oh;
   logic [3:0]         win;
   logic               accept;
   state_t             state, state_nxt;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
      irq_sync_edge u_sync (
         .clk     (clk),
         .reset_n (reset_n),
         .d       (int_src[i]),
         .rise    (rise[i])
      );
   end

   assign req = pending & int_en;
   assign irq = gie & (|req);
   assign win = prio_idx(16'(req));

   always_comb begin
      win_oh = 16'd1 << win;
      clr    = accept ? NUM_SRC'(win_oh) : '0;
   end

   // A fresh rise in the accept cycle re-pends the source.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pending <= '0;
      else          pending <= (pending & ~clr) | rise;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    cause <= '0;
      else if (accept) cause <= CAUSE_W'(win);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (take && irq) state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (rfe)         state_nxt = ST_IDLE;
         default:                    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ia_bit = (state == ST_ACTIVE);
      accept = (state == ST_IDLE) && take && irq;
   end

endmodule
